// File: rtl/display_timing_480p.sv
// 640x480 @ 60 Hz VGA raster timing generator; all outputs registered and mutually aligned.
// Define TIMING_FRAME_CNT_EN to add the 16-bit free-running frame_cnt output.
module display_timing_480p #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CORDW    = 10
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             line,
  output logic             frame
`ifdef TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last coordinate of each phase; the phase FSMs advance when the counter sits on these.
  localparam logic [CORDW-1:0] H_ACT_END  = CORDW'(H_ACTIVE - 1);
  localparam logic [CORDW-1:0] H_FP_END   = CORDW'(H_ACTIVE + H_FP - 1);
  localparam logic [CORDW-1:0] H_SYNC_END = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] H_LAST     = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_ACT_END  = CORDW'(V_ACTIVE - 1);
  localparam logic [CORDW-1:0] V_FP_END   = CORDW'(V_ACTIVE + V_FP - 1);
  localparam logic [CORDW-1:0] V_SYNC_END = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CORDW-1:0] V_LAST     = CORDW'(V_TOTAL - 1);

  typedef enum logic [1:0] {HP_ACT, HP_FP, HP_SYNC, HP_BP} h_phase_e;
  typedef enum logic [1:0] {VP_ACT, VP_FP, VP_SYNC, VP_BP} v_phase_e;

  h_phase_e         h_state, h_next;
  v_phase_e         v_state, v_next;
  logic [CORDW-1:0] sx_next, sy_next;
  logic             line_wrap;
  logic             hsync_d, vsync_d, de_d, line_d, frame_d;

  assign line_wrap = (sx == H_LAST);

  // State register: counters, phases and the registered outputs all move together.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      sx      <= H_LAST;
      sy      <= V_LAST;
      h_state <= HP_BP;
      v_state <= VP_BP;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      de      <= 1'b0;
      line    <= 1'b0;
      frame   <= 1'b0;
    end else begin
      sx      <= sx_next;
      sy      <= sy_next;
      h_state <= h_next;
      v_state <= v_next;
      hsync   <= hsync_d;
      vsync   <= vsync_d;
      de      <= de_d;
      line    <= line_d;
      frame   <= frame_d;
    end
  end

  // Next-state logic for the counters and both phase FSMs.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sx_next = sx + CORDW'(1);
    sy_next = sy;
    h_next  = h_state;
    v_next  = v_state;

    if (line_wrap) begin
      sx_next = '0;
      sy_next = (sy == V_LAST) ? '0 : sy + CORDW'(1);
    end

    unique case (h_state)
      HP_ACT:  if (sx == H_ACT_END)  h_next = HP_FP;
      HP_FP:   if (sx == H_FP_END)   h_next = HP_SYNC;
      HP_SYNC: if (sx == H_SYNC_END) h_next = HP_BP;
      HP_BP:   if (line_wrap)        h_next = HP_ACT;
    endcase

    if (line_wrap) begin
      unique case (v_state)
        VP_ACT:  if (sy == V_ACT_END)  v_next = VP_FP;
        VP_FP:   if (sy == V_FP_END)   v_next = VP_SYNC;
        VP_SYNC: if (sy == V_SYNC_END) v_next = VP_BP;
        VP_BP:   if (sy == V_LAST)     v_next = VP_ACT;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in the same cycle as sx/sy.
  always_comb begin
    hsync_d = (h_next != HP_SYNC);
    vsync_d = (v_next != VP_SYNC);
    de_d    = (h_next == HP_ACT) && (v_next == VP_ACT);
    line_d  = (sx_next == '0);
    frame_d = (sx_next == '0) && (sy_next == '0);
  end

`ifdef TIMING_FRAME_CNT_EN
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
    end else if (frame_d) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
